delay_timer: RTL
================

Name: delay_timer

Overview:
- Downstream stage of the 1101 sequence detector. It consumes the detector's `start_shifting` flag.
- After a new assertion of `start_shifting`, it shifts in a 4-bit delay value from the serial `data` line, MSB first.
- It then times (delay+1)×CYCLES_PER_UNIT clock cycles, asserting `counting` and exposing the remaining units on `count`.
- Finally it raises `done` and holds it until the user acknowledges with `ack`.

Parameters:
- SHIFT_BITS, 4, number of delay bits shifted in; also the width of `count`.
- CYCLES_PER_UNIT, 1000, clock cycles per delay unit (benches override to 10).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start_shifting  input  1  from the sequence detector; may stay high (sticky) after detection.
- data  input  1  serial stream shared with the detector; carries the delay bits MSB first.
- ack  input  1  user acknowledge; sampled only in DONE.
- counting  output  1  high while in COUNT.
- done  output  1  high while in DONE.
- count  output  SHIFT_BITS  remaining delay units while in COUNT; 0 in all other states.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; delay register, bit counter and unit counter cleared.
  - start_prev=1, so a start already high when reset releases is not treated as a new start.
  - counting=0, done=0, count=0.
  - Reset mid-operation aborts immediately, with no partial output.
- Outputs are Moore, decoded from registered state only; no output depends combinationally on an input.
- Start detection:
  - start_prev registers start_shifting every cycle.
  - trigger = start_shifting & ~start_prev.
  - A sticky high start never retriggers.
- IDLE:
  - On the edge where trigger=1: go to SHIFT, bit counter=0. No data bit is sampled on this edge.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each edge: delay <= {delay[SHIFT_BITS-2:0], data}; bit counter +1.
  - On the SHIFT_BITS-th sample: go to COUNT, load count=shifted delay value, unit counter=0.
  - Exactly SHIFT_BITS cycles are spent in SHIFT.
- COUNT:
  - Unit counter increments each edge.
  - At CYCLES_PER_UNIT-1, the unit counter wraps to 0 and:
    - if count==0, go to DONE;
    - otherwise count decrements.
  - Total time in COUNT = (delay+1)×CYCLES_PER_UNIT cycles.
  - count shows delay, delay-1, …, 0, each held for CYCLES_PER_UNIT cycles.
- DONE:
  - done=1 until ack is sampled 1 on an edge, then go to IDLE.
  - ack already high on entry completes on the first DONE edge, so done lasts 1 cycle.
- Inputs ignored by state:
  - start_shifting and trigger are ignored outside IDLE.
  - ack is ignored outside DONE.
  - data is ignored outside SHIFT.
- Widths:
  - Unit counter width = $clog2(CYCLES_PER_UNIT).
  - Unit counter compares against the constant CYCLES_PER_UNIT-1.
  - No arithmetic overflow is possible: count only decrements while nonzero.
- After DONE→IDLE, a new run requires start_shifting to fall and rise again, i.e. detector reset and re-detect.

Decomposition:
- Shared package holds:
  - state typedef: IDLE, SHIFT, COUNT, DONE (2-bit encoding);
  - default constants SHIFT_BITS_DEF=4 and CYCLES_PER_UNIT_DEF=1000.
- One natural sub-module: unit_tick_counter.
  - Parameterised modulo-CYCLES_PER_UNIT counter with enable and clear.
  - Outputs a single-cycle `tick` at the terminal count.
- The FSM, shift register and count register stay in delay_timer.

Test Plan (CYCLES_PER_UNIT=10):
- Basic run:
  - Stimulus: reset low 2 cycles, release; start_shifting rises; data 0,1,0,1 on the next 4 edges.
  - Required: counting=1 for exactly 60 cycles; count = 5,4,3,2,1,0, each held 10 cycles; then done=1.
  - Then: ack=1 for one cycle returns the block to IDLE with done=0.
- Delay boundaries:
  - Bits 0000 → counting for 10 cycles with count=0.
  - Bits 1111 → counting for 160 cycles, count starting at 15.
- Sticky start:
  - Stimulus: start_shifting stays high through a full run and after ack.
  - Required: block stays in IDLE; no second SHIFT.
  - Then: drop start for 1 cycle and re-raise → a new run starts.
- Ignored inputs:
  - ack=1 held throughout SHIFT and COUNT → no effect; done pulses for exactly 1 cycle on DONE entry.
  - start_shifting toggling and random data during COUNT → count sequence unchanged.
- Reset mid-count:
  - Stimulus: assert reset low asynchronously (between clock edges) at cycle 25 of COUNT.
  - Required: counting=0 and count=0 immediately, without waiting for a clock edge.
  - Then: after release the block idles until a fresh start rising edge.
- Timing alignment:
  - Stimulus: start rises one cycle after the detector's last `1` sample.
  - Required: the first data bit sampled is on the cycle after the trigger edge. Bench checks the MSB by sending 1000 → count starts at 8.

Source files
------------

// File: rtl/delay_timer_pkg.sv
// Shared definitions for the delay_timer block.
//   state_t              : FSM state encoding (IDLE, SHIFT, COUNT, DONE)
//   SHIFT_BITS_DEF       : default number of serial delay bits
//   CYCLES_PER_UNIT_DEF  : default clock cycles per delay unit
package delay_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        COUNT = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int unsigned SHIFT_BITS_DEF      = 4;
    localparam int unsigned CYCLES_PER_UNIT_DEF = 1000;

endpackage

// File: rtl/delay_timer_unit_tick_counter.sv
// Modulo-CYCLES_PER_UNIT up-counter that marks the end of each delay unit.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   en     : advance the counter this cycle
//   clr    : synchronous clear to zero (wins over en)
//   tick   : single-cycle pulse while enabled at the terminal count
module unit_tick_counter
    import delay_timer_pkg::*;
#(
    parameter int unsigned CYCLES_PER_UNIT = CYCLES_PER_UNIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(CYCLES_PER_UNIT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == TERM) ? '0 : cnt + ONE;
        end
    end

    assign tick = en && !clr && (cnt == TERM);

endmodule

// File: rtl/delay_timer.sv
// Delay timer downstream of the 1101 sequence detector.
// After a fresh rise of start_shifting it shifts SHIFT_BITS delay bits in
// from data (MSB first), counts (delay+1)*CYCLES_PER_UNIT cycles, then holds
// done until ack.
//   clk            : system clock, rising edge
//   reset          : asynchronous active-low reset
//   start_shifting : start flag from the detector (may stay high)
//   data           : serial delay bits, MSB first
//   ack            : acknowledge, only looked at in DONE
//   counting       : high while in COUNT
//   done           : high while in DONE
//   count          : remaining delay units while in COUNT, else 0
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a rising edge of start_shifting
// SHIFT | sampling SHIFT_BITS delay bits from data
// COUNT | timing; count shows remaining units
// DONE  | done high until ack
module delay_timer
    import delay_timer_pkg::*;
#(
    parameter int unsigned SHIFT_BITS      = SHIFT_BITS_DEF,
    parameter int unsigned CYCLES_PER_UNIT = CYCLES_PER_UNIT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_shifting,
    input  logic                  data,
    input  logic                  ack,
    output logic                  counting,
    output logic                  done,
    output logic [SHIFT_BITS-1:0] count
);

    localparam int unsigned BW = (SHIFT_BITS > 1) ? $clog2(SHIFT_BITS) : 1;
    localparam logic [BW-1:0]         BIT_LAST  = BW'(SHIFT_BITS - 1);
    localparam logic [BW-1:0]         BIT_ONE   = BW'(1);
    localparam logic [SHIFT_BITS-1:0] UNIT_ONE  = SHIFT_BITS'(1);

    state_t                state;
    logic                  start_prev;
    logic [BW-1:0]         bit_cnt;
    // Serves as the shift register during SHIFT and as the remaining-unit
    // counter during COUNT; the value is only exposed while counting.
    logic [SHIFT_BITS-1:0] delay_q;
    logic [SHIFT_BITS-1:0] shifted;
    logic                  counting_q;
    logic                  done_q;
    logic                  trigger;
    logic                  tick;

    assign trigger = start_shifting & ~start_prev;
    assign shifted = {delay_q[SHIFT_BITS-2:0], data};

    unit_tick_counter #(
        .CYCLES_PER_UNIT (CYCLES_PER_UNIT)
    ) u_unit_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state == COUNT),
        .clr   (state != COUNT),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            start_prev <= 1'b1;
            bit_cnt    <= '0;
            delay_q    <= '0;
            counting_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_prev <= start_shifting;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    delay_q <= shifted;
                    bit_cnt <= bit_cnt + BIT_ONE;
                    if (bit_cnt == BIT_LAST) begin
                        state      <= COUNT;
                        counting_q <= 1'b1;
                    end
                end
                COUNT: begin
                    if (tick) begin
                        if (delay_q == '0) begin
                            state      <= DONE;
                            counting_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            delay_q <= delay_q - UNIT_ONE;
                        end
                    end
                end
                DONE: begin
                    if (ack) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    counting_q <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign counting = counting_q;
    assign done     = done_q;
    assign count    = counting_q ? delay_q : '0;

endmodule
